// File: rtl/vga_pixel_fifo_pkg.sv
// Shared parameters for the VGA pixel path: 640x480@60 timing plus pixel FIFO sizing.
// Pure declarations; no logic, no latency, no flow control.
// Consumers import vga_pixel_fifo_pkg::* and take defaults from here.
package vga_pixel_fifo_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_SYNC_CYC   = 96;
    localparam int H_SYNC_BACK  = 48;
    localparam int H_SYNC_ACT   = 640;
    localparam int H_SYNC_FRONT = 16;
    localparam int H_SYNC_TOTAL = H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT + H_SYNC_FRONT;

    // Vertical timing in lines
    localparam int V_SYNC_CYC   = 2;
    localparam int V_SYNC_BACK  = 33;
    localparam int V_SYNC_ACT   = 480;
    localparam int V_SYNC_FRONT = 10;
    localparam int V_SYNC_TOTAL = V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT + V_SYNC_FRONT;

    // Pixel FIFO sizing: one active line plus headroom
    localparam int PIX_DEPTH    = 1024;
    localparam int PIX_AW       = 10;
    localparam int PIX_AFULL_TH = 896;

    localparam int PIX_CW = 10;

    typedef struct packed {
        logic [PIX_CW-1:0] red;
        logic [PIX_CW-1:0] green;
        logic [PIX_CW-1:0] blue;
    } pixel_t;

    localparam int PIX_W = $bits(pixel_t);

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port pixel store, one write and one read port on the same clock.
// Read data registered: valid one cycle after iRdEn; read-before-write on address collision.
// No flow control; the owner guarantees addresses and enables are legal.
module pixel_fifo_ram
    import vga_pixel_fifo_pkg::*;
#(
    parameter int AW    = PIX_AW,
    parameter int DEPTH = 1 << AW
) (
    input  logic          iCLK,
    input  logic          iWrEn,
    input  logic [AW-1:0] iWrAddr,
    input  pixel_t        iWrData,
    input  logic          iRdEn,
    input  logic [AW-1:0] iRdAddr,
    output pixel_t        oRdData
);

    pixel_t mem [DEPTH];

    // No reset: contents are don't-care until written, and the owner gates the output.
    always_ff @(posedge iCLK) begin
        if (iWrEn) begin
            mem[iWrAddr] <= iWrData;
        end
        if (iRdEn) begin
            oRdData <= mem[iRdAddr];
        end
    end

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO between a pixel source and the VGA timing controller, with level/flag/error tracking.
// Latency: popped pixel appears on oRed/oGreen/oBlue with oRD_VALID one cycle after iRD_REQ.
// Backpressure: oWR_READY = !oFULL; a write at full is accepted only alongside a pop, else dropped.
module vga_pixel_fifo
    import vga_pixel_fifo_pkg::*;
#(
    parameter int DEPTH    = PIX_DEPTH,
    parameter int AW       = PIX_AW,
    parameter int AFULL_TH = PIX_AFULL_TH
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iWR_EN,
    input  logic [PIX_CW-1:0] iWR_R,
    input  logic [PIX_CW-1:0] iWR_G,
    input  logic [PIX_CW-1:0] iWR_B,
    output logic              oWR_READY,
    input  logic              iRD_REQ,
    output logic [PIX_CW-1:0] oRed,
    output logic [PIX_CW-1:0] oGreen,
    output logic [PIX_CW-1:0] oBlue,
    output logic              oRD_VALID,
    input  logic              iFLUSH,
    input  logic              iCLR_ERR,
    output logic [AW:0]       oLEVEL,
    output logic              oEMPTY,
    output logic              oFULL,
    output logic              oALMOST_FULL,
    output logic              oUNDERFLOW,
    output logic              oOVERFLOW
);

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AFULL = (AW+1)'(AFULL_TH);

    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic [AW:0] wrPtrNxt;
    logic [AW:0] rdPtrNxt;
    logic [AW:0] levelNxt;
    logic        doPop;
    logic        doWrite;
    logic        ufEvent;
    logic        ofEvent;
    logic        rdVld;
    pixel_t      wrPix;
    pixel_t      rdPix;

    assign wrPix = '{red: iWR_R, green: iWR_G, blue: iWR_B};

    // Decisions use registered flags only, so a same-cycle write never falls through an empty FIFO.
    always_comb begin
        doPop    = iRD_REQ && !oEMPTY;
        doWrite  = iWR_EN && (!oFULL || doPop);
        ufEvent  = iRD_REQ && oEMPTY;
        ofEvent  = iWR_EN && oFULL && !doPop;
        wrPtrNxt = wrPtr;
        rdPtrNxt = rdPtr;
        if (iFLUSH) begin
            wrPtrNxt = '0;
            rdPtrNxt = '0;
        end else begin
            if (doWrite) begin
                wrPtrNxt = wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtrNxt = rdPtr + PTR_ONE;
            end
        end
        // Wrap bit makes the difference span 0..DEPTH without aliasing full onto empty.
        levelNxt = wrPtrNxt - rdPtrNxt;
    end

    pixel_fifo_ram #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .iCLK    (iCLK),
        .iWrEn   (doWrite && !iFLUSH),
        .iWrAddr (wrPtr[AW-1:0]),
        .iWrData (wrPix),
        .iRdEn   (doPop && !iFLUSH),
        .iRdAddr (rdPtr[AW-1:0]),
        .oRdData (rdPix)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            oLEVEL       <= '0;
            oEMPTY       <= 1'b1;
            oFULL        <= 1'b0;
            oALMOST_FULL <= 1'b0;
            rdVld        <= 1'b0;
            oUNDERFLOW   <= 1'b0;
            oOVERFLOW    <= 1'b0;
        end else begin
            wrPtr        <= wrPtrNxt;
            rdPtr        <= rdPtrNxt;
            oLEVEL       <= levelNxt;
            oEMPTY       <= (levelNxt == '0);
            oFULL        <= (levelNxt == LVL_FULL);
            oALMOST_FULL <= (levelNxt >= LVL_AFULL);
            rdVld        <= doPop && !iFLUSH;
            // A fresh error in the clear cycle keeps the flag set.
            oUNDERFLOW   <= ufEvent || (oUNDERFLOW && !iCLR_ERR);
            oOVERFLOW    <= ofEvent || (oOVERFLOW && !iCLR_ERR);
        end
    end

    assign oWR_READY = !oFULL;
    assign oRD_VALID = rdVld;

    // RAM output holds stale data between pops; blank it unless this cycle carries a popped pixel.
    always_comb begin
        oRed   = '0;
        oGreen = '0;
        oBlue  = '0;
        if (rdVld) begin
            oRed   = rdPix.red;
            oGreen = rdPix.green;
            oBlue  = rdPix.blue;
        end
    end

endmodule
